// File: rtl/sys_rst_tick_gen.sv
// rtl/sys_rst_tick_gen.sv - lock/button qualified system reset sequencer with 1 us / 1 ms tick strobes (optional LOCK_LOSS_CNT_EN)
`timescale 1ns/1ps

module sys_rst_tick_gen #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int HOLD_CYCLES = 16,
    parameter int DEB_CYCLES  = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       btn_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       tick_us,
    output logic       tick_ms,
`ifdef LOCK_LOSS_CNT_EN
    output logic [7:0] lock_loss_cnt,
`endif
    output logic [1:0] state
);

    // Cycles of clk per microsecond; the prescaler wraps at US_DIV-1.
    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [US_W-1:0]   US_LAST   = US_W'(US_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [9:0]        MS_LAST   = 10'd999;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic              lock_m;
    logic              lock_s;
    logic              btn_m;
    logic              btn_s;
    logic              btn_db;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [9:0]        ms_cnt;
    logic              run_ok;
    logic              counting;

    assign state = cur_state;

    // The system may run only while the clock is locked and the button is released.
    assign run_ok = lock_s & ~btn_db;

    // Prescaler runs only for cycles that both start and end in RUN.
    assign counting = (cur_state == RUN) && (nxt_state == RUN);

    // Two-flop synchronizers for the asynchronous lock and button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            lock_m <= locked;
            lock_s <= lock_m;
            btn_m  <= btn_rst;
            btn_s  <= btn_m;
        end
    end

    // Debounce: accept a new button level only after it differs for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Next-state decode; the unused code falls back to WAIT_LOCK.
    always_comb begin
        nxt_state = WAIT_LOCK;
        case (cur_state)
            WAIT_LOCK: begin
                nxt_state = run_ok ? HOLD : WAIT_LOCK;
            end
            HOLD: begin
                if (!run_ok) begin
                    nxt_state = WAIT_LOCK;
                end else if (hold_cnt == HOLD_LAST) begin
                    nxt_state = RUN;
                end else begin
                    nxt_state = HOLD;
                end
            end
            RUN: begin
                nxt_state = run_ok ? RUN : WAIT_LOCK;
            end
            default: begin
                nxt_state = WAIT_LOCK;
            end
        endcase
    end

    // Sequencer state, hold counter and registered reset/ready taken from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= WAIT_LOCK;
            hold_cnt  <= '0;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            sys_rst   <= (nxt_state != RUN);
            ready     <= (nxt_state == RUN);
            if ((cur_state == HOLD) && (nxt_state == HOLD)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Microsecond and millisecond prescaler with registered one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt  <= '0;
            ms_cnt  <= '0;
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end else if (!counting) begin
            us_cnt  <= '0;
            ms_cnt  <= '0;
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end else if (us_cnt == US_LAST) begin
            us_cnt  <= '0;
            tick_us <= 1'b1;
            if (ms_cnt == MS_LAST) begin
                ms_cnt  <= '0;
                tick_ms <= 1'b1;
            end else begin
                ms_cnt  <= ms_cnt + 1'b1;
                tick_ms <= 1'b0;
            end
        end else begin
            us_cnt  <= us_cnt + 1'b1;
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    // Saturating count of RUN exits in which the lock was lost (button-only exits are excluded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= 8'd0;
        end else if ((cur_state == RUN) && !lock_s && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sys_rst_tick_gen.sv
// tb/tb_sys_rst_tick_gen.sv - self-checking bench for sys_rst_tick_gen
`timescale 1ns/1ps

module tb_sys_rst_tick_gen;

    localparam int CLK_HZ      = 25_000_000;
    localparam int HOLD_CYCLES = 16;
    localparam int DEB_CYCLES  = 8;
    localparam int US_DIV      = CLK_HZ / 1_000_000;
    localparam int RUN_STREAK  = HOLD_CYCLES + 1;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       locked  = 1'b1;
    logic       btn_rst = 1'b0;
    logic       sys_rst;
    logic       ready;
    logic       tick_us;
    logic       tick_ms;
    logic [1:0] state;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    sys_rst_tick_gen #(
        .CLK_HZ      (CLK_HZ),
        .HOLD_CYCLES (HOLD_CYCLES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .btn_rst       (btn_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .tick_us       (tick_us),
        .tick_ms       (tick_ms),
`ifdef LOCK_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .state         (state)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: the system is in RUN once run_ok has held for HOLD_CYCLES+1
    // consecutive evaluations; ticks follow from the age inside RUN.
    int m_l1, m_l2, m_b1, m_b2, m_db, m_dcnt, m_streak;
    bit m_good;
`ifdef LOCK_LOSS_CNT_EN
    int m_llc;
`endif

    initial begin
        m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0;
        m_db = 0; m_dcnt = 0; m_streak = 0;
`ifdef LOCK_LOSS_CNT_EN
        m_llc = 0;
`endif
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0;
                m_db = 0; m_dcnt = 0; m_streak = 0;
`ifdef LOCK_LOSS_CNT_EN
                m_llc = 0;
`endif
            end else begin
                m_good = (m_l2 == 1) && (m_db == 0);
`ifdef LOCK_LOSS_CNT_EN
                if (m_streak >= RUN_STREAK && m_l2 == 0 && m_llc < 255)
                    m_llc = m_llc + 1;
`endif
                m_streak = m_good ? m_streak + 1 : 0;
                if (m_b2 != m_db) begin
                    m_dcnt = m_dcnt + 1;
                    if (m_dcnt == DEB_CYCLES) begin
                        m_db   = m_b2;
                        m_dcnt = 0;
                    end
                end else begin
                    m_dcnt = 0;
                end
                m_l2 = m_l1;
                m_l1 = int'(locked);
                m_b2 = m_b1;
                m_b1 = int'(btn_rst);
            end
        end
    end

    int c_age;
    bit c_run;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                c_run = (m_streak >= RUN_STREAK);
                c_age = m_streak - RUN_STREAK;
                chk("cyc_sys_rst", int'(sys_rst), c_run ? 0 : 1);
                chk("cyc_ready", int'(ready), c_run ? 1 : 0);
                chk("cyc_state", int'(state), c_run ? 2 : (m_streak > 0 ? 1 : 0));
                chk("cyc_tick_us", int'(tick_us),
                    (c_run && c_age > 0 && (c_age % US_DIV) == 0) ? 1 : 0);
                chk("cyc_tick_ms", int'(tick_ms),
                    (c_run && c_age > 0 && (c_age % (1000 * US_DIV)) == 0) ? 1 : 0);
`ifdef LOCK_LOSS_CNT_EN
                chk("cyc_lock_loss_cnt", int'(lock_loss_cnt), m_llc);
`endif
            end
        end
    end

    int found;

    initial begin
        rst = 1'b1; locked = 1'b1; btn_rst = 1'b0;
        wait_edges(1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_tick_us", int'(tick_us), 0);
        chk("rst_tick_ms", int'(tick_ms), 0);
        chk("rst_state", int'(state), 0);
        cmp_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Power-up sequencing
        wait_edges(18);
        chk("pwr_e18_sys_rst", int'(sys_rst), 1);
        chk("pwr_e18_state", int'(state), 1);
        wait_edges(1);
        chk("pwr_e19_sys_rst", int'(sys_rst), 0);
        chk("pwr_e19_ready", int'(ready), 1);
        chk("pwr_e19_state", int'(state), 2);

        // Tick timing relative to E = edge 19
        wait_edges(24);
        chk("tick_e24", int'(tick_us), 0);
        wait_edges(1);
        chk("tick_e25", int'(tick_us), 1);
        wait_edges(1);
        chk("tick_e26", int'(tick_us), 0);
        wait_edges(24);
        chk("tick_e50", int'(tick_us), 1);
        wait_edges(25000 - 50 - 1);
        chk("tick_ms_e24999", int'(tick_ms), 0);
        wait_edges(1);
        chk("tick_ms_e25000", int'(tick_ms), 1);
        chk("tick_us_e25000", int'(tick_us), 1);
        wait_edges(1);
        chk("tick_ms_e25001", int'(tick_ms), 0);

        // Lock drop in RUN and restore
        @(negedge clk); locked = 1'b0;
        wait_edges(2);
        chk("lockdrop_e2_sys_rst", int'(sys_rst), 0);
        wait_edges(1);
        chk("lockdrop_e3_sys_rst", int'(sys_rst), 1);
        chk("lockdrop_e3_tick_us", int'(tick_us), 0);
        chk("lockdrop_e3_tick_ms", int'(tick_ms), 0);
        chk("lockdrop_e3_state", int'(state), 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("lockdrop_llc", int'(lock_loss_cnt), 1);
`endif
        repeat (5) @(negedge clk);
        locked = 1'b1;
        wait_edges(18);
        chk("relock_e18_sys_rst", int'(sys_rst), 1);
        wait_edges(1);
        chk("relock_e19_sys_rst", int'(sys_rst), 0);

        // Button bounce: five 3-cycle pulses
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); btn_rst = 1'b1;
            repeat (3) @(negedge clk);
            btn_rst = 1'b0;
            repeat (4) @(negedge clk);
        end
        wait_edges(12);
        chk("bounce_sys_rst", int'(sys_rst), 0);

        // Steady press, then release
        @(negedge clk); btn_rst = 1'b1;
        wait_edges(10);
        chk("press_e10_sys_rst", int'(sys_rst), 0);
        wait_edges(1);
        chk("press_e11_sys_rst", int'(sys_rst), 1);
        @(negedge clk); btn_rst = 1'b0;
        wait_edges(26);
        chk("release_e26_sys_rst", int'(sys_rst), 1);
        wait_edges(1);
        chk("release_e27_sys_rst", int'(sys_rst), 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("btn_exit_llc", int'(lock_loss_cnt), 1);
`endif

        // Abort during HOLD at hold_cnt = 10
        @(negedge clk); locked = 1'b0;
        wait_edges(3);
        chk("abort_pre_state", int'(state), 0);
        @(negedge clk); locked = 1'b1;
        wait_edges(13);
        chk("abort_hold10_state", int'(state), 1);
        @(negedge clk); locked = 1'b0;
        @(negedge clk); locked = 1'b1;
        wait_edges(1);
        chk("abort_r1_state", int'(state), 1);
        wait_edges(1);
        chk("abort_r2_state", int'(state), 0);
        wait_edges(16);
        chk("abort_r18_sys_rst", int'(sys_rst), 1);
        wait_edges(1);
        chk("abort_r19_sys_rst", int'(sys_rst), 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("abort_llc", int'(lock_loss_cnt), 2);
`endif

        // Asynchronous reset while a tick is high
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick_us) begin
                found = 1;
                break;
            end
        end
        chk("async_tick_seen", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_sys_rst", int'(sys_rst), 1);
        chk("async_ready", int'(ready), 0);
        chk("async_tick_us", int'(tick_us), 0);
        chk("async_tick_ms", int'(tick_ms), 0);
        chk("async_state", int'(state), 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("async_llc", int'(lock_loss_cnt), 0);
`endif
        rst = 1'b0;
        wait_edges(18);
        chk("async_e18_sys_rst", int'(sys_rst), 1);
        wait_edges(1);
        chk("async_e19_sys_rst", int'(sys_rst), 0);
        chk("async_e19_ready", int'(ready), 1);

        wait_edges(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
